// File: rtl/fifo_sched_pkg.sv
// Shared types and the rotating-priority pick used by the FIFO read scheduler.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
// Contents: sched_state_t (IDLE/READ), rr_pick_t result, rr_pick(req, ptr, n).
package fifo_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } sched_state_t;

  // The pick function is sized for the largest supported source count; callers
  // zero-extend their request vector and narrow the returned index.
  localparam int RR_MAX_N = 16;
  localparam int RR_IDX_W = 4;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First requester found searching ptr+1, ptr+2, ... modulo n. Walking the
  // offsets from far to near lets the nearest requester overwrite the result,
  // which keeps the loop bound static and free of early exits.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int                  n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int off = RR_MAX_N; off >= 1; off--) begin
      j = int'(ptr) + off;
      if (j >= n) j = j - n;
      if (off <= n && req[RR_IDX_W'(j)]) begin
        r.found = 1'b1;
        r.idx   = RR_IDX_W'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational rotating-priority arbiter: picks the first set req after ptr.
// Latency: 0 cycles (combinational).
// Backpressure: none; the caller decides when to accept idx.
// Ports: req[N] request vector, ptr last-served index, idx chosen index, valid any request.
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(RR_MAX_N'(req), RR_IDX_W'(ptr), N);
    idx   = W'(pick.idx);
    valid = pick.found;
  end

endmodule

// File: rtl/fifo_rd_scheduler.sv
// Round-robin read scheduler draining N_SRC source FIFOs into one tagged stream.
// Latency: read issued in cycle k, source data in k+1, out_dv/out_data/out_src_id in k+2.
// Backpressure: out_full stalls reads (no rotation); up to 2 in-flight words still emerge.
// Ports: clk/rst (sync, active high), enable, src_empty/src_dv/src_data from the
//        sources, src_rd_en to the sources, out_full from the consumer,
//        out_data/out_dv/out_src_id to the consumer, busy status.
module fifo_rd_scheduler
  import fifo_sched_pkg::*;
#(
  parameter  int N_SRC      = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST      = 4,
  localparam int ID_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [N_SRC-1:0]            src_empty,
  input  logic [N_SRC-1:0]            src_dv,
  input  logic [N_SRC*DATA_WIDTH-1:0] src_data,
  output logic [N_SRC-1:0]            src_rd_en,
  input  logic                        out_full,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_dv,
  output logic [ID_W-1:0]             out_src_id,
  output logic                        busy
);

  localparam int              CNT_W    = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);

  sched_state_t     state;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id_q;
  logic [CNT_W-1:0] burst_cnt;
  logic             pend;

  logic [ID_W-1:0]  arb_idx;
  logic             arb_vld;
  logic             rd_fire;
  logic             rd_exit;
  logic             fwd;

  rr_arbiter #(
    .N (N_SRC),
    .W (ID_W)
  ) u_arb (
    .req   (~src_empty),
    .ptr   (rr_ptr),
    .idx   (arb_idx),
    .valid (arb_vld)
  );

  // A read needs the granted source to have data and the consumer to have room.
  // enable is included so that dropping it stops new reads in the same cycle;
  // rst is included so no read strobe leaks out while the block is held in reset.
  always_comb begin
    rd_fire = !rst && (state == READ) && enable && !src_empty[grant] && !out_full;
    rd_exit = src_empty[grant] || !enable || (rd_fire && (burst_cnt == LAST_CNT));
  end

  assign src_rd_en = rd_fire ? (N_SRC'(1) << grant) : '0;

  // The word read two cycles ago is forwarded only if its source flagged it valid.
  assign fwd  = pend && src_dv[id_q];
  assign busy = (state == READ) || pend || out_dv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      burst_cnt  <= '0;
      rr_ptr     <= ID_W'(N_SRC - 1);
      pend       <= 1'b0;
      id_q       <= '0;
      out_dv     <= 1'b0;
      out_data   <= '0;
      out_src_id <= '0;
    end else begin
      pend <= rd_fire;
      if (rd_fire) begin
        burst_cnt <= burst_cnt + 1'b1;
        id_q      <= grant;
      end

      case (state)
        IDLE: begin
          if (enable && arb_vld) begin
            grant     <= arb_idx;
            burst_cnt <= '0;
            state     <= READ;
          end
        end
        READ: begin
          // Exiting through IDLE costs one arbitration cycle; the next search
          // starts just after the source that was served.
          if (rd_exit) begin
            state  <= IDLE;
            rr_ptr <= grant;
          end
        end
        default: state <= IDLE;
      endcase

      out_dv     <= fwd;
      out_src_id <= id_q;
      if (fwd) out_data <= src_data[id_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// Self-checking bench for fifo_rd_scheduler with queue-backed source FIFO models.
// Expected word order, tags and arrival spacing come from a burst-level round-robin model.
module tb_fifo_rd_scheduler;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;
  localparam int IDW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            out_full;
  logic [N-1:0]    src_empty = '1;
  logic [N-1:0]    src_dv    = '0;
  logic [N*DW-1:0] src_data  = '0;
  logic [N-1:0]    src_rd_en;
  logic [DW-1:0]   out_data;
  logic            out_dv;
  logic [IDW-1:0]  out_src_id;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DW-1:0] src_q [N][$];
  int            rd_cnt [N] = '{default: 0};

  logic [DW-1:0] exp_data [$];
  int            exp_id   [$];
  int            exp_gap  [$];
  logic [DW-1:0] obs_data [$];
  int            obs_id   [$];
  int            obs_cyc  [$];
  int            snap_rd     [N];
  int            exp_per_src [N];
  int            m_ptr;
  bit            mon_en   = 1'b0;
  int            full_run = 0;

  fifo_rd_scheduler #(
    .N_SRC      (N),
    .DATA_WIDTH (DW),
    .BURST      (BURST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .src_empty  (src_empty),
    .src_dv     (src_dv),
    .src_data   (src_data),
    .src_rd_en  (src_rd_en),
    .out_full   (out_full),
    .out_data   (out_data),
    .out_dv     (out_dv),
    .out_src_id (out_src_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source FIFO models: data/dv registered one cycle after rd_en, empty registered.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (src_rd_en[i]) begin
        rd_cnt[i] = rd_cnt[i] + 1;
        if (src_q[i].size() > 0) begin
          src_data[i*DW +: DW] <= src_q[i].pop_front();
          src_dv[i]            <= 1'b1;
        end else begin
          src_dv[i] <= 1'b0;
        end
      end else begin
        src_dv[i] <= 1'b0;
      end
      src_empty[i] <= (src_q[i].size() == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Output monitor and per-cycle protocol checks.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rd_en_onehot0", 32'($onehot0(src_rd_en)), 32'd1);
      if (out_full) begin
        full_run++;
        chk("rd_en_while_full", 32'(src_rd_en), 32'd0);
      end else begin
        full_run = 0;
      end
      if (out_dv === 1'b1) begin
        obs_data.push_back(out_data);
        obs_id.push_back(int'(out_src_id));
        obs_cyc.push_back(cyc);
        chk("dv_beyond_slack", 32'(full_run >= 3), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int s, input int n);
    for (int k = 0; k < n; k++) src_q[s].push_back(DW'($urandom));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    enable   = 1'b0;
    out_full = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    tick();
    tick();
    rst   = 1'b0;
    m_ptr = N - 1;
  endtask

  // Burst-level model: pick the next non-empty source after the last served one,
  // take min(BURST, remaining) words. Arrival spacing: back-to-back inside a burst,
  // two cycles across a grant change, three after a drained (partial) burst because
  // the source's empty flag is only seen the cycle after its last read.
  task automatic build_expected();
    logic [DW-1:0] mq [N][$];
    int  s, n, sel;
    bit  first, prev_partial;
    exp_data.delete(); exp_id.delete(); exp_gap.delete();
    obs_data.delete(); obs_id.delete(); obs_cyc.delete();
    for (int i = 0; i < N; i++) begin
      mq[i]          = src_q[i];
      snap_rd[i]     = rd_cnt[i];
      exp_per_src[i] = 0;
    end
    first        = 1'b1;
    prev_partial = 1'b0;
    for (int b = 0; b < 100; b++) begin
      s = -1;
      for (int off = 1; off <= N; off++) begin
        sel = (m_ptr + off) % N;
        if (s < 0 && mq[sel].size() > 0) s = sel;
      end
      if (s < 0) break;
      n = (mq[s].size() < BURST) ? mq[s].size() : BURST;
      for (int j = 0; j < n; j++) begin
        exp_data.push_back(mq[s].pop_front());
        exp_id.push_back(s);
        if (j > 0)             exp_gap.push_back(1);
        else if (first)        exp_gap.push_back(3);
        else if (prev_partial) exp_gap.push_back(3);
        else                   exp_gap.push_back(2);
      end
      exp_per_src[s] += n;
      prev_partial   = (n < BURST);
      first          = 1'b0;
      m_ptr          = s;
    end
  endtask

  task automatic collect(input string tag, input int c_start, input bit chk_tm,
                         input bit bp, input int stall_at);
    int guard      = 0;
    int stall_left = 0;
    bit stalled    = 1'b0;
    int lim;
    while (obs_data.size() < exp_data.size() && guard < 600) begin
      if (stall_at > 0 && !stalled && obs_data.size() >= stall_at) begin
        stalled    = 1'b1;
        stall_left = 5;
      end
      out_full = (stall_left > 0) || (bp && ($urandom_range(0, 2) == 0));
      if (stall_left > 0) stall_left--;
      tick();
      guard++;
    end
    out_full = 1'b0;
    chk({tag, "_timeout"}, 32'(guard < 600), 32'd1);
    repeat (8) tick();
    chk({tag, "_count"}, 32'(obs_data.size()), 32'(exp_data.size()));
    lim = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
    for (int k = 0; k < lim; k++) begin
      chk({tag, "_data"}, 32'(obs_data[k]), 32'(exp_data[k]));
      chk({tag, "_id"},   32'(obs_id[k]),   32'(exp_id[k]));
      if (chk_tm) begin
        if (k == 0) chk({tag, "_first_lat"}, 32'(obs_cyc[0] - c_start), 32'(exp_gap[0]));
        else        chk({tag, "_gap"}, 32'(obs_cyc[k] - obs_cyc[k-1]), 32'(exp_gap[k]));
      end
    end
    if (stall_at > 0) chk({tag, "_stall_seen"}, 32'(stalled), 32'd1);
    for (int i = 0; i < N; i++)
      chk({tag, "_rd_count"}, 32'(rd_cnt[i] - snap_rd[i]), 32'(exp_per_src[i]));
  endtask

  task automatic run_traffic(input string tag, input bit chk_tm, input bit bp, input int stall_at);
    int c;
    tick();                // let the source empty flags settle after loading
    build_expected();
    c      = cyc;
    enable = 1'b1;
    collect(tag, c, chk_tm, bp, stall_at);
    enable = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [DW-1:0] w0, w1;

    rst      = 1'b1;
    enable   = 1'b0;
    out_full = 1'b0;
    tick();
    tick();
    chk("rst_out_dv",     32'(out_dv),     32'd0);
    chk("rst_out_data",   32'(out_data),   32'd0);
    chk("rst_out_src_id", 32'(out_src_id), 32'd0);
    chk("rst_rd_en",      32'(src_rd_en),  32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    rst    = 1'b0;
    m_ptr  = N - 1;
    mon_en = 1'b1;
    tick();

    // Single source with three words.
    load(2, 3);
    run_traffic("basic", 1'b1, 1'b0, 0);

    // All sources full: strict 4-word rotation.
    for (int s = 0; s < N; s++) load(s, 8);
    run_traffic("fair", 1'b1, 1'b0, 0);

    // Short source drains mid-burst, long source re-granted on its own.
    load(1, 2);
    load(3, 5);
    run_traffic("early_empty", 1'b1, 1'b0, 0);

    // 5-cycle consumer stall inside source 0's burst must not rotate the grant.
    load(0, 4);
    load(1, 4);
    run_traffic("stall", 1'b0, 1'b0, 1);

    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < N; s++) load(s, $urandom_range(0, 9));
      run_traffic("rand", 1'b1, 1'b0, 0);
    end
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < N; s++) load(s, $urandom_range(0, 9));
      run_traffic("rand_bp", 1'b0, 1'b1, 0);
    end

    // enable drops right after the second read of a burst.
    do_reset();
    load(2, 4);
    tick();
    w0 = src_q[2][0];
    w1 = src_q[2][1];
    snap_rd[2] = rd_cnt[2];
    obs_data.delete(); obs_id.delete(); obs_cyc.delete();
    enable = 1'b1;
    tick();
    tick();
    tick();
    enable = 1'b0;
    tick();
    tick();
    tick();
    chk("endrop_busy",   32'(busy),                     32'd0);
    chk("endrop_rd_en",  32'(src_rd_en),                32'd0);
    chk("endrop_reads",  32'(rd_cnt[2] - snap_rd[2]),   32'd2);
    chk("endrop_count",  32'(obs_data.size()),          32'd2);
    if (obs_data.size() >= 2) begin
      chk("endrop_w0", 32'(obs_data[0]), 32'(w0));
      chk("endrop_w1", 32'(obs_data[1]), 32'(w1));
      chk("endrop_id", 32'(obs_id[1]),   32'd2);
    end

    // One-cycle reset in the middle of a burst from source 1.
    do_reset();
    load(1, 4);
    tick();
    c      = cyc;
    enable = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    load(0, 2);
    #1;
    chk("rst_mid_rd_en_in_rst", 32'(src_rd_en), 32'd0);
    tick();
    chk("rst_mid_out_dv", 32'(out_dv),    32'd0);
    chk("rst_mid_rd_en",  32'(src_rd_en), 32'd0);
    chk("rst_mid_busy",   32'(busy),      32'd0);
    m_ptr = N - 1;
    build_expected();
    c   = cyc;
    rst = 1'b0;
    collect("after_rst", c, 1'b1, 1'b0, 0);
    enable = 1'b0;
    tick();

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_scheduler.md
Name: fifo_rd_scheduler

Overview:
- Round-robin read scheduler that drains N_SRC source FIFOs into one shared consumer stream.
- Each source FIFO has the team's standard read side: rd_en in, empty out, registered data/dv out one cycle after a read.
- The block grants one source at a time for a burst of up to BURST words.
- It tags each forwarded word with its source index and respects consumer backpressure.

Parameters:
- N_SRC, 4, number of source FIFOs (2..16).
- DATA_WIDTH, 8, word width; must match the source FIFOs.
- BURST, 4, max consecutive reads from one source before rotating (1..255).
- ID_W, $clog2(N_SRC) (min 1), width of the source index; derived localparam.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- enable  in  1  1 = scheduling allowed; 0 = finish current word, then idle.
- src_empty  in  N_SRC  per-source FIFO empty flag.
- src_dv  in  N_SRC  per-source FIFO output data valid.
- src_data  in  N_SRC*DATA_WIDTH  packed source outputs; source i at [i*DATA_WIDTH +: DATA_WIDTH].
- src_rd_en  out  N_SRC  one-hot (or zero) read enable to sources.
- out_full  in  1  consumer almost-full; consumer guarantees ≥2 words of slack after asserting it.
- out_data  out  DATA_WIDTH  forwarded word.
- out_dv  out  1  out_data valid, single-cycle per word.
- out_src_id  out  ID_W  source index of out_data.
- busy  out  1  1 when state==READ or a read is in flight.

Behaviour:
- Reset values: every register is reset.
  - state=IDLE, grant=0, burst_cnt=0, rr_ptr=N_SRC-1 (so source 0 has first priority), pend=0, id_q=0.
  - out_dv=0, out_data=0, out_src_id=0.
  - src_rd_en=0 during reset.
- FSM has 2 states, IDLE and READ.
- IDLE:
  - If enable and any !src_empty: grant<=first non-empty index searching rr_ptr+1, rr_ptr+2, … mod N_SRC; burst_cnt<=0; go READ.
  - Otherwise stay in IDLE.
  - src_rd_en=0 in IDLE.
- READ: src_rd_en[grant]=1 (combinational) iff !src_empty[grant] && !out_full; all other bits 0.
  - On each issued read: burst_cnt<=burst_cnt+1, pend<=1, id_q<=grant.
  - With no read issued: pend<=0.
- READ exit to IDLE, with rr_ptr<=grant, when any of:
  - src_empty[grant];
  - !enable;
  - a read issued with burst_cnt==BURST-1.
- out_full in READ: stall with no read; burst_cnt and state held. The stall alone never forces a rotation.
- Latency: rd_en cycle k → source dv in cycle k+1 → out_dv, out_data, out_src_id registered in cycle k+2.
- Output register, every edge: out_dv<=pend && src_dv[id_q]; out_data<=src_data[id_q]; out_src_id<=id_q.
  - out_data changes only when out_dv=1; otherwise it holds.
- Throughput:
  - 1 word/cycle within a burst.
  - 1 idle cycle per grant change, spent in IDLE for arbitration.
- Fairness: with all sources non-empty and BURST=4, the grant order is 0,1,2,3,0,… with 4 words each.
- Boundary conditions:
  - Granted source goes empty mid-burst: no read is issued that cycle and the FSM exits. Partial bursts are allowed.
  - Single non-empty source: it is re-granted after one IDLE cycle.
  - enable falls mid-burst: the in-flight word is still forwarded; no new read is issued.
  - Reset mid-burst: synchronous clear; the in-flight word is dropped and out_dv=0 on the next cycle.
- busy = (state==READ) || pend || out_dv.

Decomposition:
- Shared package fifo_sched_pkg holds:
  - typedef enum logic {IDLE, READ} sched_state_t;
  - function rr_pick(req, ptr), returning index and found flag.
- One sub-module: rr_arbiter, purely combinational rotating-priority pick.
  - Parameter N; inputs req[N] and ptr; outputs idx and valid.
  - Unit-testable on its own.

Test Plan:
- Basic path: N_SRC=4, only source 2 holds words A,B,C → exactly three out_dv pulses with data A,B,C and out_src_id=2; first out_dv 3 cycles after enable rises; src_rd_en only ever 4'b0100.
- Round-robin fairness: all 4 sources hold 8 words, BURST=4 → out_src_id sequence 0×4, 1×4, 2×4, 3×4, 0×4, 1×4, 2×4, 3×4; 32 words total, in per-source order.
- Backpressure: hold out_full=1 for 5 cycles mid-burst → src_rd_en=0 during the stall; ≤2 further out_dv after assertion; no word lost or duplicated; burst resumes on the same grant.
- Early empty: source 1 has 2 words, BURST=4, source 3 has 5 words → sequence 1,1,3,3,3,3, IDLE, 3 (the fifth word from source 3 comes in its next burst).
- enable drop: deassert enable after the 2nd read of a burst → the 2nd word is still forwarded; no further src_rd_en; busy falls within 3 cycles.
- Reset mid-burst: assert rst for 1 cycle during READ → next cycle out_dv=0, src_rd_en=0, state=IDLE; after release, source 0 is granted first.
